key_readout: RTL and testbench

- Reader side of the key-generation output RAMs (u, n, g, lambda).
- After keygen asserts done, this block walks the shared out_rd_addr over entries 0..num_words-1.
- For each entry it captures all four DATA_WIDTH words and serializes them onto a narrow valid/ready stream for host/DMA transfer, in fixed order n, g, lambda, u, each word LSB beat first.

---
 rtl/key_io_pkg.sv | 23 ++
 rtl/key_piso.sv | 61 ++++++
 rtl/key_readout.sv | 107 ++++++++++
 tb/tb_key_readout.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_io_pkg.sv
// rtl/key_io_pkg.sv - shared types and helpers for the key RAM readout path
package key_io_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    CAPTURE = 3'd2,
    STREAM  = 3'd3,
    DONE    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    KEY_N      = 2'd0,
    KEY_G      = 2'd1,
    KEY_LAMBDA = 2'd2,
    KEY_U      = 2'd3
  } key_field_t;

  function automatic int beats(input int data_width, input int out_width);
    return data_width / out_width;
  endfunction

endpackage

// File: rtl/key_piso.sv
// rtl/key_piso.sv - parallel-in serial-out of one captured entry {u,lambda,g,n}, n beats first
module key_piso
  import key_io_pkg::*;
#(
  parameter int DATA_WIDTH = 1024,
  parameter int OUT_WIDTH  = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    i_load,
  input  logic [4*DATA_WIDTH-1:0] i_din,
  input  logic                    i_valid,
  input  logic                    i_tready,
  input  logic                    i_last_entry,
  output logic [OUT_WIDTH-1:0]    o_tdata,
  output logic                    o_tvalid,
  output logic                    o_tlast,
  output logic [1:0]              o_tkey,
  output logic                    o_entry_end
);

  localparam int BEATS = beats(DATA_WIDTH, OUT_WIDTH);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [4*DATA_WIDTH-1:0] r_shreg;
  logic [BW-1:0]           r_beat;
  logic [1:0]              r_word;
  logic                    w_last_beat;
  logic                    w_hs;

  assign w_hs        = i_valid && i_tready;
  assign w_last_beat = (r_beat == BW'(BEATS - 1));
  assign o_entry_end = w_last_beat && (r_word == 2'(KEY_U));

  // State only moves on a handshake, which keeps tdata/tkey/tlast stable under backpressure.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_shreg <= '0;
      r_beat  <= '0;
      r_word  <= '0;
    end else if (i_load) begin
      r_shreg <= i_din;
      r_beat  <= '0;
      r_word  <= '0;
    end else if (w_hs) begin
      r_shreg <= r_shreg >> OUT_WIDTH;
      if (w_last_beat) begin
        r_beat <= '0;
        r_word <= r_word + 2'd1;
      end else begin
        r_beat <= r_beat + BW'(1);
      end
    end
  end

  assign o_tvalid = i_valid;
  assign o_tdata  = i_valid ? r_shreg[OUT_WIDTH-1:0] : '0;
  assign o_tkey   = i_valid ? r_word : 2'd0;
  assign o_tlast  = i_valid && o_entry_end && i_last_entry;

endmodule

// File: rtl/key_readout.sv
// rtl/key_readout.sv - walks the key RAMs after keygen and streams each entry as n, g, lambda, u
module key_readout
  import key_io_pkg::*;
#(
  parameter int DATA_WIDTH     = 1024,
  parameter int RAM_ADDR_WIDTH = 5,
  parameter int RAM_SIZE       = 32,
  parameter int OUT_WIDTH      = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [RAM_ADDR_WIDTH:0]   num_words,
  output logic                      busy,
  output logic                      done,
  output logic [RAM_ADDR_WIDTH-1:0] out_rd_addr,
  input  logic [DATA_WIDTH-1:0]     n_dout,
  input  logic [DATA_WIDTH-1:0]     g_dout,
  input  logic [DATA_WIDTH-1:0]     lambda_dout,
  input  logic [DATA_WIDTH-1:0]     u_dout,
  output logic [OUT_WIDTH-1:0]      m_tdata,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic [1:0]                m_tkey,
  output logic                      m_tlast
);

  localparam int AW1 = RAM_ADDR_WIDTH + 1;

  generate
    if (DATA_WIDTH % OUT_WIDTH != 0) begin : g_bad_width
      $error("key_readout: DATA_WIDTH must be a multiple of OUT_WIDTH");
    end
  endgenerate

  state_t                    r_state;
  state_t                    w_next;
  logic [AW1-1:0]            r_cnt;
  logic [AW1-1:0]            r_addr;
  logic [AW1-1:0]            w_num_clamped;
  logic [RAM_ADDR_WIDTH-1:0] r_rd_addr;
  logic                      w_accept;
  logic                      w_hs;
  logic                      w_entry_end;
  logic                      w_last_entry;

  assign w_accept      = (r_state == IDLE) && start;
  assign w_num_clamped = (num_words > AW1'(RAM_SIZE)) ? AW1'(RAM_SIZE) : num_words;
  assign w_hs          = m_tvalid && m_tready;
  assign w_last_entry  = ((r_addr + AW1'(1)) == r_cnt);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = (w_num_clamped == '0) ? DONE : FETCH;
      FETCH:   w_next = CAPTURE;
      CAPTURE: w_next = STREAM;
      STREAM:  if (w_hs && w_entry_end) w_next = w_last_entry ? DONE : FETCH;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The read address is updated on entry to FETCH so the RAMs see it for the whole FETCH cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_addr    <= '0;
      r_rd_addr <= '0;
    end else if (w_accept) begin
      r_cnt     <= w_num_clamped;
      r_addr    <= '0;
      r_rd_addr <= '0;
    end else if ((r_state == STREAM) && w_hs && w_entry_end) begin
      r_addr <= r_addr + AW1'(1);
      if (!w_last_entry) r_rd_addr <= RAM_ADDR_WIDTH'(r_addr + AW1'(1));
    end
  end

  key_piso #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH)
  ) u_piso (
    .clock        (clock),
    .reset        (reset),
    .i_load       (r_state == CAPTURE),
    .i_din        ({u_dout, lambda_dout, g_dout, n_dout}),
    .i_valid      (r_state == STREAM),
    .i_tready     (m_tready),
    .i_last_entry (w_last_entry),
    .o_tdata      (m_tdata),
    .o_tvalid     (m_tvalid),
    .o_tlast      (m_tlast),
    .o_tkey       (m_tkey),
    .o_entry_end  (w_entry_end)
  );

  assign busy        = (r_state != IDLE);
  assign done        = (r_state == DONE);
  assign out_rd_addr = r_rd_addr;

endmodule

// File: tb/tb_key_readout.sv
// tb/tb_key_readout.sv - directed bench for key_readout with a registered key RAM model
module tb_key_readout;

  localparam int DW  = 1024;
  localparam int AW  = 5;
  localparam int RS  = 32;
  localparam int OW  = 32;
  localparam int BPE = 4 * (DW / OW);

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   num_words = '0;
  logic          busy, done;
  logic [AW-1:0] out_rd_addr;
  logic [DW-1:0] n_dout, g_dout, lambda_dout, u_dout;
  logic [OW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic [1:0]    m_tkey;
  logic          m_tlast;

  logic [DW-1:0] n_mem [0:RS-1];
  logic [DW-1:0] g_mem [0:RS-1];
  logic [DW-1:0] l_mem [0:RS-1];
  logic [DW-1:0] u_mem [0:RS-1];

  int n_checks = 0;
  int n_fails  = 0;

  int beats, lasts, last_idx, dones, done_cycle, first_valid, busy_cycles, max_addr;
  logic [31:0] cap_data [0:BPE-1];
  logic [1:0]  cap_key  [0:BPE-1];

  key_readout #(
    .DATA_WIDTH     (DW),
    .RAM_ADDR_WIDTH (AW),
    .RAM_SIZE       (RS),
    .OUT_WIDTH      (OW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .num_words   (num_words),
    .busy        (busy),
    .done        (done),
    .out_rd_addr (out_rd_addr),
    .n_dout      (n_dout),
    .g_dout      (g_dout),
    .lambda_dout (lambda_dout),
    .u_dout      (u_dout),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tkey      (m_tkey),
    .m_tlast     (m_tlast)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    n_dout      <= n_mem[out_rd_addr];
    g_dout      <= g_mem[out_rd_addr];
    lambda_dout <= l_mem[out_rd_addr];
    u_dout      <= u_mem[out_rd_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int i);
    int e, k, b;
    e = i / BPE;
    k = (i % BPE) / (DW / OW);
    b = i % (DW / OW);
    case (k)
      0:       return n_mem[e][b*32 +: 32];
      1:       return g_mem[e][b*32 +: 32];
      2:       return l_mem[e][b*32 +: 32];
      default: return u_mem[e][b*32 +: 32];
    endcase
  endfunction

  // One readout: pulse start, then per cycle drive tready, score beats and check stall stability.
  task automatic run_xfer(input int nw, input int rdy_pct, input int mid_start_cycle,
                          input int reset_at_beat, input int budget);
    int          c;
    int          total;
    bit          prev_stall;
    logic [31:0] p_data;
    logic [1:0]  p_key;
    logic        p_last;
    beats = 0; lasts = 0; last_idx = -1; dones = 0; done_cycle = -1;
    first_valid = -1; busy_cycles = 0; max_addr = 0;
    total = ((nw > RS) ? RS : nw) * BPE;
    prev_stall = 1'b0; p_data = '0; p_key = '0; p_last = 1'b0;
    @(negedge clock);
    start = 1'b1;
    num_words = (AW+1)'(nw);
    m_tready = 1'b0;
    c = 0;
    forever begin
      @(negedge clock);
      c++;
      start = 1'b0;
      if (reset_at_beat >= 0 && beats == reset_at_beat) begin
        chk("pre_reset_rd_addr", out_rd_addr, 64'(reset_at_beat / BPE));
        reset = 1'b0;
        #1;
        chk("rst_mid_tvalid", m_tvalid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_rd_addr", out_rd_addr, 0);
        chk("rst_mid_tlast", m_tlast, 0);
        return;
      end
      if (c == mid_start_cycle) begin
        start = 1'b1;
        num_words = (AW+1)'(3);
      end
      if (prev_stall) begin
        chk("stall_tvalid", m_tvalid, 1);
        chk("stall_tdata", m_tdata, p_data);
        chk("stall_tkey", m_tkey, p_key);
        chk("stall_tlast", m_tlast, p_last);
      end
      m_tready = ($urandom_range(0, 99) < rdy_pct);
      busy_cycles += int'(busy);
      if (int'(out_rd_addr) > max_addr) max_addr = int'(out_rd_addr);
      if (m_tvalid) begin
        if (first_valid < 0) first_valid = c;
        if (m_tready) begin
          chk("beat_rd_addr", out_rd_addr, 64'(beats / BPE));
          chk("beat_tdata", m_tdata, exp_word(beats));
          chk("beat_tkey", m_tkey, 64'((beats % BPE) / (DW / OW)));
          chk("beat_tlast", m_tlast, 64'(beats == total - 1));
          if (beats < BPE) begin
            cap_data[beats] = m_tdata;
            cap_key[beats]  = m_tkey;
          end
          if (m_tlast) begin
            lasts++;
            last_idx = beats;
          end
          beats++;
        end
        prev_stall = !m_tready;
        p_data = m_tdata; p_key = m_tkey; p_last = m_tlast;
      end else begin
        prev_stall = 1'b0;
      end
      if (done) begin
        dones++;
        if (done_cycle < 0) done_cycle = c;
      end
      if (done_cycle >= 0 && c == done_cycle + 1) begin
        chk("post_done_busy", busy, 0);
        chk("post_done_done", done, 0);
        chk("post_done_tvalid", m_tvalid, 0);
        m_tready = 1'b0;
        return;
      end
      if (c >= budget) begin
        chk("xfer_timeout", 1, 0);
        m_tready = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int e = 0; e < RS; e++) begin
      for (int j = 0; j < DW / 32; j++) begin
        n_mem[e][j*32 +: 32] = {8'(e), 8'h00, 16'(j)};
        g_mem[e][j*32 +: 32] = {8'(e), 8'h11, 16'(j)};
        l_mem[e][j*32 +: 32] = {8'(e), 8'h22, 16'(j)};
        u_mem[e][j*32 +: 32] = {8'(e), 8'h33, 16'(j)};
      end
    end
    n_mem[0] = '0;
    n_mem[0][31:0]  = 32'h2;
    n_mem[0][63:32] = 32'h1;
    g_mem[0] = {(DW/32){32'hA5A5A5A5}};
    l_mem[0] = DW'(7);
    u_mem[0] = DW'(3);

    repeat (3) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tkey", m_tkey, 0);
    chk("rst_rd_addr", out_rd_addr, 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Single entry, tready held high.
    run_xfer(1, 100, -1, -1, 400);
    chk("s_beats", beats, 128);
    chk("s_first_valid", first_valid, 3);
    chk("s_beat0", cap_data[0], 32'h2);
    chk("s_key0", cap_key[0], 0);
    chk("s_beat1", cap_data[1], 32'h1);
    chk("s_beat32", cap_data[32], 32'hA5A5A5A5);
    chk("s_key32", cap_key[32], 1);
    chk("s_beat64", cap_data[64], 32'h7);
    chk("s_key64", cap_key[64], 2);
    chk("s_beat96", cap_data[96], 32'h3);
    chk("s_key96", cap_key[96], 3);
    chk("s_lasts", lasts, 1);
    chk("s_last_idx", last_idx, 127);
    chk("s_done_cycle", done_cycle, 131);
    chk("s_dones", dones, 1);
    chk("s_busy_cycles", busy_cycles, 131);

    // Two entries under random backpressure.
    run_xfer(2, 30, -1, -1, 5000);
    chk("bp_beats", beats, 256);
    chk("bp_lasts", lasts, 1);
    chk("bp_last_idx", last_idx, 255);
    chk("bp_max_addr", max_addr, 1);
    chk("bp_dones", dones, 1);

    // Zero entries.
    run_xfer(0, 100, -1, -1, 50);
    chk("z_beats", beats, 0);
    chk("z_first_valid", first_valid, -1);
    chk("z_done_cycle", done_cycle, 1);
    chk("z_busy_cycles", busy_cycles, 1);

    // Clamp 40 down to 32 entries.
    run_xfer(40, 100, -1, -1, 6000);
    chk("c_beats", beats, 4096);
    chk("c_last_idx", last_idx, 4095);
    chk("c_lasts", lasts, 1);
    chk("c_max_addr", max_addr, 31);
    chk("c_dones", dones, 1);

    // Start pulsed while streaming must be dropped.
    run_xfer(1, 100, 50, -1, 400);
    chk("m_beats", beats, 128);
    chk("m_dones", dones, 1);
    chk("m_done_cycle", done_cycle, 131);
    repeat (3) @(negedge clock);
    chk("m_idle_busy", busy, 0);
    chk("m_idle_tvalid", m_tvalid, 0);

    // Reset partway into the second entry, then a clean single-entry run.
    run_xfer(2, 100, -1, BPE + 50, 600);
    @(negedge clock);
    chk("rst_hold_tvalid", m_tvalid, 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_rel_busy", busy, 0);
    chk("rst_rel_tvalid", m_tvalid, 0);
    run_xfer(1, 100, -1, -1, 400);
    chk("r_beats", beats, 128);
    chk("r_beat0", cap_data[0], 32'h2);
    chk("r_key0", cap_key[0], 0);
    chk("r_last_idx", last_idx, 127);
    chk("r_dones", dones, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
